i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_target.sv | 181 ++++++++++++++++++
 tb/tb_i2c_target.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and default bus address
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK
  } i2c_state_t;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h54;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - synchronizer plus rise/fall detect for one I2C line
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 1 so an idle pulled-up bus never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target: address match, byte receive with ACK, byte transmit
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rw,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .line(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .line(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // done_q marks "8 bits sampled, waiting for the SCL fall that starts the ACK slot".
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    take       = 1'b0;
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 3'd0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise && !done_q) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              done_d = 1'b1;
              if (state_q == ST_ADDR) begin
                rw_d = sda_lvl;
              end else begin
                rx_data_d  = {shift_q[6:0], sda_lvl};
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_RX) begin
              sda_oe_d = 1'b1;
              state_d  = ST_RX_ACK;
            end else if (shift_q[7:1] == TARGET_ADDR) begin
              sda_oe_d = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (rw_q) take = 1'b1;
            else      state_d = ST_RX;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              bit_cnt_d  = bit_cnt_q + 3'd1;
              tx_shift_d = tx_shift_q << 1;
              sda_oe_d   = ~tx_shift_q[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !done_q) begin
            if (sda_lvl) state_d = ST_IDLE;
            else         done_d  = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            take   = 1'b1;
          end
        end
        default: ;
      endcase
      // Loading a transmit byte also drives its MSB in the same cycle.
      if (take) begin
        state_d    = ST_TX;
        bit_cnt_d  = 3'd0;
        tx_shift_d = tx_data;
        sda_oe_d   = ~tx_data[7];
      end
    end
  end

  always_comb begin
    sda_oe   = sda_oe_q;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    tx_load  = take;
    rw       = rw_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized controller-side bench for i2c_target
module tb_i2c_target;

  localparam int         Q    = 4;
  localparam logic [6:0] ADDR = 7'h54;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_in, sda_in, sda_oe, rx_valid, tx_load, rw, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int         checks = 0;
  int         failures = 0;
  logic       exp_valid = 1'b0;
  logic       exp_oe = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] xfer_bytes[$];
  logic [7:0] tx_plan[$];
  logic [7:0] rd_got[$];
  int         tx_ptr = 0;
  int         rx_pulses = 0;
  int         tx_loads = 0;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target #(.TARGET_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .rw(rw), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level expectations published by the controller tasks during SCL-high phases.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_valid) begin
        check("sda_oe", 32'(sda_oe), 32'(exp_oe));
        check("busy", 32'(busy), 32'(exp_busy));
      end
      if (tx_load) tx_loads++;
      if (rx_valid) begin
        rx_pulses++;
        if (rx_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got pulse with rx_data %0h expected no pulse", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_load === 1'b1) begin
      @(posedge clk);
      #1;
      tx_ptr++;
      tx_data = (tx_ptr < tx_plan.size()) ? tx_plan[tx_ptr] : 8'hFF;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic drive, input logic oe, output logic seen);
    wait_clk(Q); sda_drv = drive;
    wait_clk(Q); scl_drv = 1'b1; exp_oe = oe; exp_valid = 1'b1;
    wait_clk(Q); seen = sda_in;
    wait_clk(Q); exp_valid = 1'b0; scl_drv = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl_drv) begin
      wait_clk(Q); sda_drv = 1'b1;
      wait_clk(Q); scl_drv = 1'b1;
    end
    wait_clk(Q); sda_drv = 1'b0; exp_busy = 1'b1;
    wait_clk(Q); scl_drv = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q); sda_drv = 1'b1; exp_busy = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic target_acks, output logic ack_seen);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, s);
    clock_bit(1'b1, target_acks, s);
    ack_seen = ~s;
  endtask

  task automatic recv_byte(input logic [7:0] expect_b, input logic ctrl_ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, ~expect_b[i], s);
      got[i] = s;
    end
    clock_bit(~ctrl_ack, 1'b0, s);
  endtask

  task automatic write_xfer(input logic [6:0] a);
    logic match, ack;
    int   rx0;
    match = (a == ADDR);
    rx0   = rx_pulses;
    start_cond();
    send_byte({a, 1'b0}, match, ack);
    check("addr_ack_w", 32'(ack), 32'(match));
    foreach (xfer_bytes[k]) begin
      if (match) rx_exp_q.push_back(xfer_bytes[k]);
      send_byte(xfer_bytes[k], match, ack);
      check("data_ack", 32'(ack), 32'(match));
    end
    stop_cond();
    check("rx_count", rx_pulses - rx0, match ? xfer_bytes.size() : 0);
    check("rw_w", 32'(rw), 32'd0);
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic plan_tx();
    tx_plan = xfer_bytes;
    tx_ptr  = 0;
    tx_data = tx_plan[0];
  endtask

  // Controller ACKs every byte but the last; after its NACK one more clock must stay quiet.
  task automatic read_xfer(input logic [6:0] a);
    logic       match, ack, s;
    logic [7:0] got;
    int         tl0, n;
    match = (a == ADDR);
    tl0   = tx_loads;
    n     = tx_plan.size();
    rd_got = {};
    start_cond();
    send_byte({a, 1'b1}, match, ack);
    check("addr_ack_r", 32'(ack), 32'(match));
    if (match) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(tx_plan[k], k != n - 1, got);
        rd_got.push_back(got);
        check("read_byte", 32'(got), 32'(tx_plan[k]));
      end
      clock_bit(1'b1, 1'b0, s);
    end
    stop_cond();
    check("tx_load_count", tx_loads - tl0, match ? n : 0);
    check("rw_r", 32'(rw), 32'd1);
    check("busy_after_stop_r", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ack, s;
    logic [6:0] a;
    int         rx0, kind, n;

    wait_clk(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Plain write of 8'h4D
    xfer_bytes = {8'h4D};
    write_xfer(ADDR);
    check("w_rx_data_lit", 32'(rx_data), 32'h4D);

    // Read of 8'hCA with controller NACK
    xfer_bytes = {8'hCA};
    plan_tx();
    read_xfer(ADDR);
    check("r_byte_lit", 32'(rd_got.size() > 0 ? rd_got[0] : 8'h00), 32'hCA);

    // Address 8'hAA does not match
    rx0 = rx_pulses;
    xfer_bytes = {8'h4D};
    write_xfer(7'h55);
    check("mismatch_no_rx", rx_pulses - rx0, 0);

    // Repeated START after 4 data bits, then a read
    rx0 = rx_pulses;
    start_cond();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    check("rs_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) clock_bit(i[0], 1'b0, s);
    xfer_bytes = {8'h5A};
    plan_tx();
    read_xfer(ADDR);
    check("rs_no_rx", rx_pulses - rx0, 0);

    // Two-byte read
    xfer_bytes = {8'h12, 8'h34};
    plan_tx();
    read_xfer(ADDR);
    check("r2_byte0_lit", 32'(rd_got.size() > 0 ? rd_got[0] : 8'h00), 32'h12);
    check("r2_byte1_lit", 32'(rd_got.size() > 1 ? rd_got[1] : 8'h00), 32'h34);

    // Reset while the target drives a 0 bit
    xfer_bytes = {8'h12};
    plan_tx();
    start_cond();
    send_byte({ADDR, 1'b1}, 1'b1, ack);
    check("rstx_addr_ack", 32'(ack), 32'd1);
    wait_clk(Q);
    check("rstx_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    exp_busy = 1'b0;
    check("rstx_sda_oe", 32'(sda_oe), 32'd0);
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_rx_data", 32'(rx_data), 32'h00);
    xfer_bytes = {8'h4D};
    write_xfer(ADDR);
    check("rstx_w_lit", 32'(rx_data), 32'h4D);

    // Randomized transfers
    for (int t = 0; t < 16; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      a    = ADDR;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom);
        if (a == ADDR) a = a ^ 7'h01;
      end
      xfer_bytes = {};
      for (int k = 0; k < n; k++) xfer_bytes.push_back(8'($urandom));
      if (kind < 2) begin
        write_xfer(a);
      end else begin
        plan_tx();
        read_xfer(a);
      end
    end

    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
